pixel_loader: RTL and testbench

- Upstream feeder for the two-layer `net` classifier.
- Accepts a serial stream of unsigned 8-bit pixels over a valid/ready handshake and converts each to IEEE-754 single precision as pixel/256.
- Packs the converted values into the flat I*S-bit input vector `x`.
- When a full frame is assembled, holds `x` stable and issues a one-cycle `start` pulse to the network. It accepts no new pixels until the network reports completion.

---
 rtl/pixel_loader.sv | 117 +++++++++++
 tb/tb_pixel_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_loader.sv
// pixel_loader: collects a frame of 8-bit pixels, converts each to a
// single-precision float equal to pixel/256, and presents the frame to the
// downstream network with a one-cycle start pulse.
//
// state | meaning
// ------+-----------------------------------------------------------------
// LOAD  | accepting pixels; cnt is the next element to write
// FULL  | frame complete, x frozen; waits for net_done (ignored 1st cycle)
module pixel_loader #(
  parameter int I = 784,
  parameter int S = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     pix,
  input  logic           pix_valid,
  input  logic           pix_sof,
  output logic           pix_ready,
  output logic [I*S-1:0] x,
  output logic           frame_valid,
  output logic           start,
  input  logic           net_done
);

  localparam int CNT_W = (I > 1) ? $clog2(I) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(I - 1);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [S-1:0]     x_mem [I];
  logic [S-1:0]     pix_f;

  // Exact conversion of an unsigned byte to float(p/256); every value fits
  // in the 23-bit mantissa so no rounding is involved.
  function automatic logic [31:0] byte_to_float(input logic [7:0] p);
    int          k;
    logic [30:0] sh;
    logic [31:0] f;
    k  = 0;
    sh = '0;
    f  = '0;
    if (p != 8'd0) begin
      for (int i = 0; i < 8; i++) begin
        if (p[i]) k = i;
      end
      sh = 31'(p) << (23 - k);
      f  = {1'b0, 8'(119 + k), sh[22:0]};
    end
    return f;
  endfunction

  // Converted value of the pixel currently on the input.
  always_comb begin
    pix_f = byte_to_float(pix);
  end

  // Ready is a pure decode of the registered state, independent of pix_valid.
  assign pix_ready = (state == LOAD);

  // Flatten the element store onto the output vector.
  for (genvar g = 0; g < I; g++) begin : g_flat
    assign x[g*S +: S] = x_mem[g];
  end

  // Frame assembly and hand-off FSM; start doubles as the first-FULL-cycle
  // marker so a stale net_done from the previous frame is skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      cnt         <= '0;
      frame_valid <= 1'b0;
      start       <= 1'b0;
      for (int i = 0; i < I; i++) x_mem[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (pix_valid) begin
            if (pix_sof) begin
              x_mem[0] <= pix_f;
              cnt      <= CNT_W'(1);
            end else begin
              x_mem[cnt] <= pix_f;
              if (cnt == LAST) begin
                state       <= FULL;
                cnt         <= '0;
                frame_valid <= 1'b1;
                start       <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
        end
        FULL: begin
          if (start) begin
            start <= 1'b0;
          end else if (net_done) begin
            state       <= LOAD;
            frame_valid <= 1'b0;
          end
        end
        default: begin
          state       <= LOAD;
          cnt         <= '0;
          frame_valid <= 1'b0;
          start       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_loader.sv
// Self-checking bench for pixel_loader with a small frame (I=4): directed
// scenarios followed by random traffic, all compared against a frame-level
// reference model.
module tb_pixel_loader;
  localparam int I = 4;
  localparam int S = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     pix = '0;
  logic           pix_valid = 1'b0;
  logic           pix_sof = 1'b0;
  logic           net_done = 1'b0;
  logic           pix_ready;
  logic [I*S-1:0] x;
  logic           frame_valid;
  logic           start;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_full;
  bit          m_first;
  int          m_cnt;
  logic [31:0] m_x [I];

  pixel_loader #(.I(I), .S(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix        (pix),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .x          (x),
    .frame_valid(frame_valid),
    .start      (start),
    .net_done   (net_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // p/256 via real arithmetic, repacked from double to single precision.
  function automatic logic [31:0] ref_float(input logic [7:0] p);
    real         r;
    logic [63:0] d;
    logic [10:0] e;
    if (p == 8'd0) return 32'h0;
    r = real'(p) / 256.0;
    d = $realtobits(r);
    e = d[62:52];
    return {1'b0, 8'(e - 11'd896), d[51:29]};
  endfunction

  task automatic model_reset();
    m_full  = 1'b0;
    m_first = 1'b0;
    m_cnt   = 0;
    for (int k = 0; k < I; k++) m_x[k] = 32'h0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] p, input bit sof, input bit done);
    if (!m_full) begin
      if (v) begin
        if (sof) begin
          m_x[0] = ref_float(p);
          m_cnt  = 1;
        end else begin
          m_x[m_cnt] = ref_float(p);
          m_cnt++;
          if (m_cnt == I) begin
            m_full  = 1'b1;
            m_first = 1'b1;
            m_cnt   = 0;
          end
        end
      end
    end else if (m_first) begin
      m_first = 1'b0;
    end else if (done) begin
      m_full = 1'b0;
    end
  endtask

  task automatic compare(input string ph);
    check({ph, " ready"}, 32'(pix_ready), 32'(!m_full));
    check({ph, " frame_valid"}, 32'(frame_valid), 32'(m_full));
    check({ph, " start"}, 32'(start), 32'(m_full && m_first));
    for (int k = 0; k < I; k++)
      check($sformatf("%s x[%0d]", ph, k), x[k*S +: S], m_x[k]);
  endtask

  // Drive one cycle's inputs, clock it, then check at the falling edge.
  task automatic cyc(input bit v, input logic [7:0] p, input bit sof, input bit done,
                     input string ph);
    pix_valid = v;
    pix       = p;
    pix_sof   = sof;
    net_done  = done;
    @(posedge clk);
    model_edge(v, p, sof, done);
    @(negedge clk);
    compare(ph);
  endtask

  initial begin
    model_reset();
    #12;
    compare("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare("post_reset");

    // single pixel with sof
    cyc(1, 8'd128, 1, 0, "t1");
    check("t1 x0 const", x[31:0], 32'h3F000000);

    // conversion corners; frame completes after 4 elements
    cyc(1, 8'd0,   1, 0, "t2a");
    cyc(1, 8'd1,   0, 0, "t2b");
    cyc(1, 8'd255, 0, 0, "t2c");
    cyc(1, 8'd2,   0, 0, "t2d");
    check("t2 e0", x[31:0],   32'h00000000);
    check("t2 e1", x[63:32],  32'h3B800000);
    check("t2 e2", x[95:64],  32'h3F7F0000);
    check("t2 e3", x[127:96], 32'h3C000000);
    check("t2 start", 32'(start), 32'd1);

    // FULL with pix_valid held high; x must not move
    for (int c = 0; c < 3; c++) cyc(1, 8'(8'd77 + c), 0, 0, "t3");
    check("t3 start gone", 32'(start), 32'd0);

    // release: next frame's element 0 overwrites, others keep old values
    cyc(0, 8'd0, 0, 1, "t4_rel");
    cyc(1, 8'd3, 1, 0, "t4_sof");
    check("t4 e0", x[31:0],  32'h3C400000);
    check("t4 e1", x[63:32], 32'h3B800000);

    // mid-frame sof then three more pixels
    cyc(1, 8'd10, 0, 0, "t5a");
    cyc(1, 8'd20, 1, 0, "t5b");
    cyc(1, 8'd30, 0, 0, "t5c");
    cyc(1, 8'd64, 1, 0, "t5_sof");
    check("t5 e0", x[31:0], 32'h3E800000);
    cyc(1, 8'd5, 0, 0, "t5d");
    cyc(1, 8'd6, 0, 0, "t5e");
    check("t5 not yet", 32'(frame_valid), 32'd0);
    cyc(1, 8'd7, 0, 0, "t5f");
    check("t5 done", 32'(frame_valid), 32'd1);

    // async reset while in FULL, between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare("t6_async");
    @(posedge clk);
    @(negedge clk);
    compare("t6_held");
    rst_n = 1'b1;
    cyc(1, 8'd200, 1, 0, "t6_after");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 1)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
